// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM state type, the data word width and the error read pattern.
package mem_resp_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WAIT = 2'd1;
  localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W storage with synchronous write and combinational read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // No reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with programmable wait states.
// Ports: clk, reset (async, active-low), MemReq/MemWrite/Adr/WriteData in,
// ReadData/MemReady/MemErr/Busy out. Define MEM_RESPONDER_ERRCHK_EN to reject
// misaligned or out-of-range addresses with MemErr and ERR_PATTERN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] Adr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemErr,
  output logic              Busy
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] adr_q, wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              rdy_q, err_q;

  logic              accept, enter_resp;
  logic              n_we, n_err;
  logic [WORD_W-1:0] n_adr, n_wdata;
  logic [WORD_W-1:0] rword, rd_d;
  logic              mem_we;

  assign accept = (state_q == S_IDLE) && MemReq;

  // Request fields as seen by the access about to enter RESP; with zero
  // wait states that happens on the accepting edge itself.
  assign n_adr   = accept ? Adr       : adr_q;
  assign n_we    = accept ? MemWrite  : we_q;
  assign n_wdata = accept ? WriteData : wdata_q;

`ifdef MEM_RESPONDER_ERRCHK_EN
  assign n_err = (n_adr[1:0] != 2'b00) ||
                 (n_adr >= WORD_W'(4 * DEPTH));
`else
  assign n_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (MemReq) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  assign rd_d = n_err ? ERR_PATTERN :
                n_we  ? n_wdata     : rword;

  // Commit on the edge leaving RESP; a reset before then drops the write.
  assign mem_we = (state_q == S_RESP) && we_q && !err_q;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (adr_q[AW+1:2]),
    .wdata (wdata_q),
    .raddr (n_adr[AW+1:2]),
    .rdata (rword)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= MemWrite;
        adr_q   <= Adr;
        wdata_q <= WriteData;
      end
      if (enter_resp) rdata_q <= rd_d;
      rdy_q <= enter_resp;
      err_q <= enter_resp && n_err;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = rdy_q;
  assign MemErr   = err_q;
  assign Busy     = (state_q == S_WAIT) || (state_q == S_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states,
// one with none; expected responses are queued and checked by monitors.
module tb_mem_responder;

  localparam int WAIT_A = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_adr = '0, a_wd = '0;
  logic [31:0] a_rd;
  logic        a_rdy, a_err, a_busy;

  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_adr = '0, b_wd = '0;
  logic [31:0] b_rd;
  logic        b_rdy, b_err, b_busy;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(WAIT_A)) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .MemReq    (a_req),
    .MemWrite  (a_we),
    .Adr       (a_adr),
    .WriteData (a_wd),
    .ReadData  (a_rd),
    .MemReady  (a_rdy),
    .MemErr    (a_err),
    .Busy      (a_busy)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .MemReq    (b_req),
    .MemWrite  (b_we),
    .Adr       (b_adr),
    .WriteData (b_wd),
    .ReadData  (b_rd),
    .MemReady  (b_rdy),
    .MemErr    (b_err),
    .Busy      (b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rdy) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_rdata", a_rd, e.rd);
          chk("a_err", {31'b0, a_err}, {31'b0, e.err});
        end
      end else if (a_err) begin
        chk("a_err_no_ready", {31'b0, a_err}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_rdy) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_rdata", b_rd, e.rd);
          chk("b_err", {31'b0, b_err}, {31'b0, e.err});
        end
      end
    end
  end

  // Starts at a negedge with DUT A idle; ends at a negedge with it idle.
  task automatic acc_a(input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input logic chg);
    int edges;
    bit seen;
    qa.push_back('{rd: exp_rd, err: exp_err});
    a_req = 1'b1;
    a_we  = we;
    a_adr = adr;
    a_wd  = wd;
    @(posedge clk);
    #1;
    a_req = 1'b0;
    if (chg) begin
      a_adr = 32'h20;
      a_we  = 1'b1;
      a_wd  = 32'hFFFF_FFFF;
    end
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (a_rdy) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk("a_latency", seen ? 32'(edges) : 32'hFFFF_FFFF,
        32'(WAIT_A + 1));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", a_rd, 32'h0);
    chk("rst_ready", {31'b0, a_rdy}, 32'd0);
    chk("rst_err", {31'b0, a_err}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    acc_a(1, 32'h10, 32'hA5A5_0001, 32'hA5A5_0001, 0, 0);
    acc_a(0, 32'h10, 32'h0, 32'hA5A5_0001, 0, 0);

    acc_a(1, 32'h04, 32'h1111_0004, 32'h1111_0004, 0, 0);
    acc_a(1, 32'h20, 32'h8888_0020, 32'h8888_0020, 0, 0);
    acc_a(0, 32'h04, 32'h0, 32'h1111_0004, 0, 1);
    acc_a(0, 32'h20, 32'h0, 32'h8888_0020, 0, 0);

    acc_a(1, 32'h08, 32'hCAFE_0008, 32'hCAFE_0008, 0, 0);
    acc_a(0, 32'h10, 32'h0, 32'hA5A5_0001, 0, 0);

    // Reset while the write to 0x08 is still waiting.
    a_req = 1'b1;
    a_we  = 1'b1;
    a_adr = 32'h08;
    a_wd  = 32'h1234_5678;
    @(posedge clk);
    #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", {31'b0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, a_busy}, 32'd0);
    chk("abort_rdata", a_rd, 32'h0);
    chk("abort_ready", {31'b0, a_rdy}, 32'd0);
    chk("abort_err", {31'b0, a_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acc_a(0, 32'h08, 32'h0, 32'hCAFE_0008, 0, 0);

    acc_a(1, 32'h00, 32'h0000_0AAA, 32'h0000_0AAA, 0, 0);
`ifdef MEM_RESPONDER_ERRCHK_EN
    acc_a(1, 32'h102, 32'hBBBB_0102, 32'hDEAD_BEEF, 1, 0);
    acc_a(0, 32'h00, 32'h0, 32'h0000_0AAA, 0, 0);
    acc_a(1, 32'h100, 32'h5555_0100, 32'hDEAD_BEEF, 1, 0);
    acc_a(0, 32'h00, 32'h0, 32'h0000_0AAA, 0, 0);
    acc_a(0, 32'h11, 32'h0, 32'hDEAD_BEEF, 1, 0);
`else
    acc_a(1, 32'h102, 32'hBBBB_0102, 32'hBBBB_0102, 0, 0);
    acc_a(0, 32'h00, 32'h0, 32'hBBBB_0102, 0, 0);
    acc_a(1, 32'h100, 32'h5555_0100, 32'h5555_0100, 0, 0);
    acc_a(0, 32'h00, 32'h0, 32'h5555_0100, 0, 0);
    acc_a(0, 32'h11, 32'h0, 32'hA5A5_0001, 0, 0);
`endif

    acc_a(1, 32'hFC, 32'h7777_00FC, 32'h7777_00FC, 0, 0);
    acc_a(0, 32'hFC, 32'h0, 32'h7777_00FC, 0, 0);
    acc_a(0, 32'h10, 32'h0, 32'hA5A5_0001, 0, 0);
    acc_a(0, 32'h20, 32'h0, 32'h8888_0020, 0, 0);

    // Zero wait states: one write, then reads with MemReq held high.
    qb.push_back('{rd: 32'h0BAD_F00D, err: 1'b0});
    b_req = 1'b1;
    b_we  = 1'b1;
    b_adr = 32'h0;
    b_wd  = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    b_req = 1'b0;
    @(negedge clk);
    chk("b_wr_ready", {31'b0, b_rdy}, 32'd1);
    @(negedge clk);
    chk("b_idle_busy", {31'b0, b_busy}, 32'd0);
    b_we = 1'b0;
    for (int i = 0; i < 3; i++) qb.push_back('{rd: 32'h0BAD_F00D, err: 1'b0});
    b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b_busy_toggle", {31'b0, b_busy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b_ready_toggle", {31'b0, b_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    b_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_idle_ready", {31'b0, b_rdy}, 32'd0);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted per access; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-005 MemReq  input  1  core requests an access; sampled only in IDLE.
REQ-006 MemWrite  input  1  1=write, 0=read; latched with the request.
REQ-007 Adr  input  32  byte address; latched with the request.
REQ-008 WriteData  input  32  store data; latched with the request.
REQ-009 ReadData  output  32  read result; valid when MemReady=1.
REQ-010 MemReady  output  1  one-cycle pulse marking access completion.
REQ-011 MemErr  output  1  qualifies MemReady; 1 = access rejected.
REQ-012 Busy  output  1  1 in WAIT and RESP states.

Function
REQ-013 FSM states IDLE, WAIT, RESP; encoding free.
REQ-014 IDLE with MemReq=1 at an edge: latch MemWrite/Adr/WriteData; go to RESP if WAIT_CYCLES=0, else WAIT with counter=WAIT_CYCLES-1.
REQ-015 WAIT: counter decrements each edge; at counter=0 go to RESP.
REQ-016 RESP lasts exactly one cycle, asserts MemReady=1, then returns to IDLE unconditionally.
REQ-017 Latency: MemReady asserts in the cycle WAIT_CYCLES+1 edges after the accepting edge.
REQ-018 MemReq, MemWrite, Adr, WriteData ignored outside IDLE; a held MemReq is re-accepted in the next IDLE cycle.
REQ-019 Word index = latched Adr[log2(DEPTH)+1:2].
REQ-020 Read: ReadData = array[index] during RESP; ReadData registered, holds last value until the next RESP.
REQ-021 Write: array[index] updated on the edge that leaves RESP; ReadData during a write RESP = WriteData.
REQ-022 Read following a write to the same word returns the new value.
REQ-023 Writes never alter any other word.
REQ-024 MemErr=0 whenever MemReady=0.

Reset
REQ-025 On reset=0: state=IDLE, counter=0, MemReady=0, MemErr=0, Busy=0, ReadData=32'h0.
REQ-026 Reset during WAIT or RESP aborts the access; pending write is not committed.
REQ-027 Array contents not affected by reset.

Configuration
REQ-028 Macro MEM_RESPONDER_ERRCHK_EN defined: an access with latched Adr[1:0]!=0 or Adr >= 4*DEPTH completes with MemReady=1, MemErr=1, write suppressed, ReadData=32'hDEAD_BEEF.
REQ-029 Macro undefined: MemErr tied 0; Adr[1:0] ignored; upper address bits ignored (index wraps modulo DEPTH).

Structure
REQ-030 Shared package mem_resp_pkg holds the state typedef, WORD_W=32, and the error-pattern constant.
REQ-031 One sub-module mem_array: DEPTH x 32 storage, synchronous write, combinational read.

Verification
REQ-032 WAIT_CYCLES=2: write Adr=0x10, WriteData=0xA5A5_0001 -> MemReady pulses 3 edges after accept, MemErr=0; then read 0x10 -> ReadData=0xA5A5_0001.
REQ-033 WAIT_CYCLES=0: MemReq held high, reads of 0x0 -> MemReady every 2nd cycle, Busy toggles 1/0.
REQ-034 Change Adr to 0x20 during WAIT of a read of 0x04 -> ReadData = contents of word 1, not word 8.
REQ-035 reset=0 in WAIT of write Adr=0x08, data 0x1234_5678 -> outputs zero immediately; later read 0x08 returns prior value.
REQ-036 ERRCHK_EN, write Adr=0x0000_0102 -> MemErr=1, ReadData=0xDEAD_BEEF, word 0x40 unchanged; without macro -> write lands in word 0x40 mod DEPTH.
REQ-037 Write 0x100 (DEPTH=64) without macro -> aliases word 0; read 0x0 returns written data.
